// File: rtl/hvac_actuator.sv
// ---------------------------------------------------------------------------
// hvac_actuator
//   Relay sequencer for a combined heater / compressor / blower unit.
//   A heat or cool request from the upstream controller starts a run. The run
//   holds its relay for at least MIN_ON cycles. It ends only when its own
//   request drops. After the run comes an optional fan-only purge of FAN_TAIL
//   cycles, then a MIN_OFF-cycle lockout with every relay off.
//
//   Build option: define HVAC_FAN_TAIL_EN to include the fan-only TAIL purge.
//   When the macro is undefined, HEAT and COOL go straight to LOCKOUT, and the
//   blower follows the heater and cooler relays.
//
// Parameters
//   MIN_ON    (1..255) minimum cycles a heat/cool run stays on
//   MIN_OFF   (1..255) lockout cycles after any run
//   FAN_TAIL  (1..255) fan-only purge cycles after a run (HVAC_FAN_TAIL_EN)
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous active-low reset
//   Heat       in   heat request
//   Cool       in   cool request
//   Heater_On  out  heater relay drive
//   Cooler_On  out  compressor relay drive
//   Fan_On     out  blower relay drive
//   Conflict   out  sticky: Heat and Cool seen high on the same edge
//   State      out  [2:0] state code (IDLE=0 HEAT=1 COOL=2 TAIL=3 LOCKOUT=4)
// ---------------------------------------------------------------------------
module hvac_actuator #(
  parameter int MIN_ON   = 8,
  parameter int MIN_OFF  = 6,
  parameter int FAN_TAIL = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Heat,
  input  logic       Cool,
  output logic       Heater_On,
  output logic       Cooler_On,
  output logic       Fan_On,
  output logic       Conflict,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEAT    = 3'd1,
    COOL    = 3'd2,
    TAIL    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // Each state leaves on the edge where its counter holds threshold-1.
  localparam logic [7:0] ON_LAST   = 8'(MIN_ON - 1);
  localparam logic [7:0] OFF_LAST  = 8'(MIN_OFF - 1);
  localparam logic [7:0] TAIL_LAST = 8'(FAN_TAIL - 1);

`ifdef HVAC_FAN_TAIL_EN
  localparam state_t RUN_EXIT = TAIL;
`else
  localparam state_t RUN_EXIT = LOCKOUT;
`endif

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_limit;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned. An unassigned path would infer a latch.
  always_comb begin
    state_nxt = IDLE;
    cnt_limit = '0;
    case (state)
      IDLE: begin
        // Both requests at once is ambiguous, so the unit stays parked.
        if (Heat && !Cool)      state_nxt = HEAT;
        else if (Cool && !Heat) state_nxt = COOL;
        else                    state_nxt = IDLE;
      end
      HEAT: begin
        // The opposite request is ignored. Only Heat dropping ends the run.
        cnt_limit = ON_LAST;
        state_nxt = (!Heat && cnt == ON_LAST) ? RUN_EXIT : HEAT;
      end
      COOL: begin
        cnt_limit = ON_LAST;
        state_nxt = (!Cool && cnt == ON_LAST) ? RUN_EXIT : COOL;
      end
      TAIL: begin
        cnt_limit = TAIL_LAST;
`ifdef HVAC_FAN_TAIL_EN
        state_nxt = (cnt == TAIL_LAST) ? LOCKOUT : TAIL;
`else
        // TAIL does not exist in this build. Treat it like an illegal code.
        state_nxt = IDLE;
`endif
      end
      LOCKOUT: begin
        cnt_limit = OFF_LAST;
        state_nxt = (cnt == OFF_LAST) ? IDLE : LOCKOUT;
      end
      default: state_nxt = IDLE;  // codes 5..7 recover to IDLE
    endcase
  end

  // Outputs are decoded from the next state and registered. A request sampled
  // in IDLE therefore drives its relay right after that same edge.
  // NOTE: non-blocking assignments keep every register updating from the
  // values present before the edge, whatever order the statements are in.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      Heater_On <= 1'b0;
      Cooler_On <= 1'b0;
      Fan_On    <= 1'b0;
      Conflict  <= 1'b0;
    end else begin
      state <= state_nxt;
      // The counter clears on entry to any state. It saturates at the exit
      // threshold so a long run cannot wrap it.
      if (state_nxt != state)  cnt <= '0;
      else if (cnt < cnt_limit) cnt <= cnt + 8'd1;

      Heater_On <= (state_nxt == HEAT);
      Cooler_On <= (state_nxt == COOL);
`ifdef HVAC_FAN_TAIL_EN
      Fan_On    <= (state_nxt == HEAT) || (state_nxt == COOL) || (state_nxt == TAIL);
`else
      Fan_On    <= (state_nxt == HEAT) || (state_nxt == COOL);
`endif
      if (Heat && Cool) Conflict <= 1'b1;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_hvac_actuator.sv
// ---------------------------------------------------------------------------
// tb_hvac_actuator
//   Directed bench for hvac_actuator with default parameters. Expected values
//   are hand-derived. The fan-only tail length follows HVAC_FAN_TAIL_EN, so
//   the same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_hvac_actuator;

  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 6;
`ifdef HVAC_FAN_TAIL_EN
  localparam int TAIL_CYC = 4;
`else
  localparam int TAIL_CYC = 0;
`endif

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Heat;
  logic       Cool;
  logic       Heater_On;
  logic       Cooler_On;
  logic       Fan_On;
  logic       Conflict;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  hvac_actuator dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Heat      (Heat),
    .Cool      (Cool),
    .Heater_On (Heater_On),
    .Cooler_On (Cooler_On),
    .Fan_On    (Fan_On),
    .Conflict  (Conflict),
    .State     (State)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_expect(input string tag, input logic h, input logic c,
                             input logic f, input logic [2:0] st);
    tick();
    check({tag, ".heater"}, 8'(Heater_On), 8'(h));
    check({tag, ".cooler"}, 8'(Cooler_On), 8'(c));
    check({tag, ".fan"},    8'(Fan_On),    8'(f));
    check({tag, ".state"},  8'(State),     8'(st));
  endtask

  // Tail (if built), then lockout, then back in IDLE. The first edge is the
  // one that ends the run.
  task automatic expect_after_run(input string tag);
    for (int i = 0; i < TAIL_CYC; i++) tick_expect({tag, ".tail"}, 0, 0, 1, 3'd3);
    for (int i = 0; i < MIN_OFF; i++)  tick_expect({tag, ".lock"}, 0, 0, 0, 3'd4);
    tick_expect({tag, ".idle"}, 0, 0, 0, 3'd0);
  endtask

  initial begin
    Reset = 1'b0;
    Heat  = 1'b0;
    Cool  = 1'b0;

    // Reset held for two edges.
    tick();
    tick_expect("reset", 0, 0, 0, 3'd0);
    check("reset.conflict", 8'(Conflict), 8'd0);
    Reset = 1'b1;
    tick_expect("idle_quiet", 0, 0, 0, 3'd0);

    // Heat pulse of two cycles: MIN_ON on, then tail, then lockout.
    Heat = 1'b1;
    tick_expect("heat.e0", 1, 0, 1, 3'd1);
    tick_expect("heat.e1", 1, 0, 1, 3'd1);
    Heat = 1'b0;
    for (int i = 2; i < MIN_ON; i++) tick_expect("heat.min_on", 1, 0, 1, 3'd1);
    expect_after_run("heat");

    // Cool held 20 cycles: the relay follows the request past MIN_ON.
    Cool = 1'b1;
    for (int i = 0; i < 20; i++) tick_expect("cool.hold", 0, 1, 1, 3'd2);
    Cool = 1'b0;
    expect_after_run("cool");

    // Heat pulse, then Cool raised during the tail/lockout. The cooler must
    // wait for IDLE and start one edge later.
    Heat = 1'b1;
    tick_expect("hc.heat0", 1, 0, 1, 3'd1);
    Heat = 1'b0;
    for (int i = 1; i < MIN_ON; i++) tick_expect("hc.heat", 1, 0, 1, 3'd1);
    Cool = 1'b1;
    expect_after_run("hc");
    tick_expect("hc.cool_start", 0, 1, 1, 3'd2);
    Cool = 1'b0;
    for (int i = 1; i < MIN_ON; i++) tick_expect("hc.cool", 0, 1, 1, 3'd2);
    expect_after_run("hc.cool_end");
    check("hc.no_conflict", 8'(Conflict), 8'd0);

    // Both requests in IDLE: stay parked, flag conflict, flag sticks.
    Heat = 1'b1;
    Cool = 1'b1;
    tick_expect("both.idle", 0, 0, 0, 3'd0);
    check("both.conflict", 8'(Conflict), 8'd1);
    Heat = 1'b0;
    Cool = 1'b0;
    tick_expect("both.drop", 0, 0, 0, 3'd0);
    tick();
    check("both.sticky", 8'(Conflict), 8'd1);
    Reset = 1'b0;
    tick_expect("both.reset", 0, 0, 0, 3'd0);
    check("both.reset_clear", 8'(Conflict), 8'd0);
    Reset = 1'b1;

    // Opposite request during HEAT is ignored but still raises Conflict.
    Heat = 1'b1;
    tick_expect("opp.heat0", 1, 0, 1, 3'd1);
    Cool = 1'b1;
    tick_expect("opp.both", 1, 0, 1, 3'd1);
    check("opp.conflict", 8'(Conflict), 8'd1);
    Heat = 1'b0;
    Cool = 1'b0;
    for (int i = 2; i < MIN_ON; i++) tick_expect("opp.heat", 1, 0, 1, 3'd1);
    expect_after_run("opp");
    Reset = 1'b0;
    tick();
    Reset = 1'b1;

    // Reset on the third HEAT cycle aborts the run at once.
    Heat = 1'b1;
    tick_expect("abort.e0", 1, 0, 1, 3'd1);
    tick_expect("abort.e1", 1, 0, 1, 3'd1);
    Reset = 1'b0;
    tick_expect("abort.reset", 0, 0, 0, 3'd0);
    Reset = 1'b1;
    Heat  = 1'b0;
    tick_expect("abort.idle", 0, 0, 0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
